// File: rtl/button_event_ctrl_if.sv
// Event port between the button event controller and its consumer.
// valid/ready handshake plus a registered drop pulse.
interface button_event_ctrl_if #(
    parameter int NUM_BTNS = 4
);
    localparam int IDX_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_btn;
    logic [1:0]       evt_type;
    logic             evt_drop;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_type,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_type,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into PRESS/HOLD/RELEASE events. Each channel
// keeps pending flags, and a round-robin arbiter serialises them onto one port.
module button_event_ctrl #(
    parameter int NUM_BTNS   = 4,
    parameter int HOLD_COUNT = 12_000_000
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    button_event_ctrl_if.master evt
);
    localparam int IDX_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
    localparam int CNT_W = (HOLD_COUNT > 2) ? $clog2(HOLD_COUNT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_COUNT - 1);
    localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(HOLD_COUNT - 2);

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_HOLD    = 2'b11
    } evt_type_e;

    logic [NUM_BTNS-1:0] prev;
    logic [NUM_BTNS-1:0] pend_p, pend_h, pend_r;
    logic [NUM_BTNS-1:0] set_p, set_h, set_r;
    logic [NUM_BTNS-1:0] gnt_p, gnt_h, gnt_r;
    logic [CNT_W-1:0]    hold_cnt [NUM_BTNS];
    logic [IDX_W-1:0]    rr_ptr, rr_next, gnt_idx, cand;
    evt_type_e           gnt_type;
    logic                gnt_found, slot_free;

    // HOLD fires on the edge where the counter reaches its saturation value,
    // so it can only happen once per press.
    always_comb begin
        set_p = btn_in & ~prev;
        set_r = ~btn_in & prev;
        set_h = '0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            set_h[i] = btn_in[i] & prev[i] & (hold_cnt[i] == HOLD_PRE);
        end
    end

    always_comb begin
        slot_free = ~evt.evt_valid | evt.evt_ready;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_type  = EVT_NONE;
        cand      = '0;
        gnt_p     = '0;
        gnt_h     = '0;
        gnt_r     = '0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % NUM_BTNS);
            if (!gnt_found && (pend_p[cand] | pend_h[cand] | pend_r[cand])) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
                if (pend_p[cand])      gnt_type = EVT_PRESS;
                else if (pend_h[cand]) gnt_type = EVT_HOLD;
                else                   gnt_type = EVT_RELEASE;
            end
        end
        if (slot_free && gnt_found) begin
            gnt_p[gnt_idx] = (gnt_type == EVT_PRESS);
            gnt_h[gnt_idx] = (gnt_type == EVT_HOLD);
            gnt_r[gnt_idx] = (gnt_type == EVT_RELEASE);
        end
        rr_next = (gnt_idx == IDX_W'(NUM_BTNS - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            prev          <= '0;
            pend_p        <= '0;
            pend_h        <= '0;
            pend_r        <= '0;
            rr_ptr        <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_btn   <= '0;
            evt.evt_type  <= '0;
            evt.evt_drop  <= 1'b0;
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            prev <= btn_in;
            // A flag being granted this edge can take a new set without loss.
            pend_p <= (pend_p & ~gnt_p) | set_p;
            pend_h <= (pend_h & ~gnt_h) | set_h;
            pend_r <= (pend_r & ~gnt_r) | set_r;
            evt.evt_drop <= |((set_p & pend_p & ~gnt_p) |
                              (set_h & pend_h & ~gnt_h) |
                              (set_r & pend_r & ~gnt_r));
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                if (btn_in[i] != prev[i]) begin
                    hold_cnt[i] <= '0;
                end else if (btn_in[i] && hold_cnt[i] != HOLD_LAST) begin
                    hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
                end
            end
            if (slot_free) begin
                if (gnt_found) begin
                    evt.evt_valid <= 1'b1;
                    evt.evt_btn   <= gnt_idx;
                    evt.evt_type  <= gnt_type;
                    rr_ptr        <= rr_next;
                end else begin
                    evt.evt_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: a per-cycle vector table plus
// hand-written hold, backpressure/drop and mid-operation reset sequences.
module tb_button_event_ctrl;
    localparam int NB = 4;
    localparam int HC = 8;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;

    button_event_ctrl_if #(.NUM_BTNS(NB)) evt_if ();

    button_event_ctrl #(.NUM_BTNS(NB), .HOLD_COUNT(HC)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .evt     (evt_if)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rst;
        logic [NB-1:0] btn;
        logic          rdy;
        logic          v;
        logic [1:0]    b;
        logic [1:0]    t;
        logic          d;
    } vec_t;

    vec_t tbl [46];

    function automatic vec_t mk(input logic r, input logic [NB-1:0] bt, input logic rd,
                                input logic v, input logic [1:0] b, input logic [1:0] t,
                                input logic d);
        vec_t x;
        x.rst = r; x.btn = bt; x.rdy = rd; x.v = v; x.b = b; x.t = t; x.d = d;
        return x;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // btn/type are compared when an event is expected or when 'full' asks for it
    task automatic chk(input string nm, input logic v, input logic [1:0] b,
                       input logic [1:0] t, input logic d, input bit full);
        total++;
        if (evt_if.evt_valid !== v || evt_if.evt_drop !== d ||
            ((full || v) && (evt_if.evt_btn !== b || evt_if.evt_type !== t))) begin
            bad++;
            $display("FAIL %s: got v=%0b btn=%0d type=%0b drop=%0b, want v=%0b btn=%0d type=%0b drop=%0b",
                     nm, evt_if.evt_valid, evt_if.evt_btn, evt_if.evt_type, evt_if.evt_drop,
                     v, b, t, d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset, press/release on btn 0, short press on btn 1
        tbl[0]  = mk(1, 4'b0000, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 4'b0000, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 4'b0001, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 4'b0001, 1, 1, 0, 1, 0);
        tbl[4]  = mk(0, 4'b0001, 1, 0, 0, 1, 0);
        tbl[5]  = mk(0, 4'b0000, 1, 0, 0, 1, 0);
        tbl[6]  = mk(0, 4'b0000, 1, 1, 0, 2, 0);
        tbl[7]  = mk(0, 4'b0000, 1, 0, 0, 2, 0);
        tbl[8]  = mk(0, 4'b0010, 1, 0, 0, 2, 0);
        tbl[9]  = mk(0, 4'b0010, 1, 1, 1, 1, 0);
        tbl[10] = mk(0, 4'b0010, 1, 0, 1, 1, 0);
        tbl[11] = mk(0, 4'b0010, 1, 0, 1, 1, 0);
        tbl[12] = mk(0, 4'b0010, 1, 0, 1, 1, 0);
        tbl[13] = mk(0, 4'b0000, 1, 0, 1, 1, 0);
        tbl[14] = mk(0, 4'b0000, 1, 1, 1, 2, 0);
        tbl[15] = mk(0, 4'b0000, 1, 0, 1, 2, 0);
        // round robin from pointer 0
        tbl[16] = mk(1, 4'b0000, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 4'b1111, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 4'b1111, 0, 1, 0, 1, 0);
        tbl[19] = mk(0, 4'b1111, 0, 1, 0, 1, 0);
        tbl[20] = mk(0, 4'b1111, 1, 1, 1, 1, 0);
        tbl[21] = mk(0, 4'b1111, 1, 1, 2, 1, 0);
        tbl[22] = mk(0, 4'b1111, 1, 1, 3, 1, 0);
        tbl[23] = mk(0, 4'b0000, 1, 0, 3, 1, 0);
        tbl[24] = mk(0, 4'b0000, 1, 1, 0, 2, 0);
        tbl[25] = mk(0, 4'b0000, 1, 1, 1, 2, 0);
        tbl[26] = mk(0, 4'b0000, 1, 1, 2, 2, 0);
        tbl[27] = mk(0, 4'b0000, 1, 1, 3, 2, 0);
        tbl[28] = mk(0, 4'b0000, 1, 0, 3, 2, 0);
        // move pointer to 2 via btn 1, then round robin 2,3,0,1
        tbl[29] = mk(0, 4'b0010, 1, 0, 3, 2, 0);
        tbl[30] = mk(0, 4'b0010, 1, 1, 1, 1, 0);
        tbl[31] = mk(0, 4'b0000, 1, 0, 1, 1, 0);
        tbl[32] = mk(0, 4'b0000, 1, 1, 1, 2, 0);
        tbl[33] = mk(0, 4'b1111, 1, 0, 1, 2, 0);
        tbl[34] = mk(0, 4'b1111, 0, 1, 2, 1, 0);
        tbl[35] = mk(0, 4'b1111, 0, 1, 2, 1, 0);
        tbl[36] = mk(0, 4'b1111, 1, 1, 3, 1, 0);
        tbl[37] = mk(0, 4'b1111, 1, 1, 0, 1, 0);
        tbl[38] = mk(0, 4'b1111, 1, 1, 1, 1, 0);
        tbl[39] = mk(0, 4'b1111, 1, 0, 1, 1, 0);
        tbl[40] = mk(0, 4'b0000, 1, 0, 1, 1, 0);
        tbl[41] = mk(0, 4'b0000, 1, 1, 2, 2, 0);
        tbl[42] = mk(0, 4'b0000, 1, 1, 3, 2, 0);
        tbl[43] = mk(0, 4'b0000, 1, 1, 0, 2, 0);
        tbl[44] = mk(0, 4'b0000, 1, 1, 1, 2, 0);
        tbl[45] = mk(0, 4'b0000, 1, 0, 1, 2, 0);

        for (int i = 0; i < 46; i++) begin
            rst              = tbl[i].rst;
            btn_in           = tbl[i].btn;
            evt_if.evt_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].b, tbl[i].t, tbl[i].d, 1'b1);
        end

        // press, hold, release on btn 2: PRESS at +2, HOLD at +9, no second HOLD
        evt_if.evt_ready = 1'b1;
        btn_in = 4'b0100;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 2)      chk($sformatf("hold_c%0d", c), 1, 2, 1, 0, 1'b0);
            else if (c == 9) chk($sformatf("hold_c%0d", c), 1, 2, 3, 0, 1'b0);
            else             chk($sformatf("hold_c%0d", c), 0, 0, 0, 0, 1'b0);
        end
        btn_in = 4'b0000;
        step(); chk("hold_fall1", 0, 0, 0, 0, 1'b0);
        step(); chk("hold_rel",   1, 2, 2, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(); chk($sformatf("hold_idle%0d", c), 0, 2, 2, 0, 1'b1);
        end

        // backpressure and drop: btn 0 occupies the slot, btn 3 toggles twice
        rst = 1'b1; evt_if.evt_ready = 1'b0;
        step(); chk("bp_reset", 0, 0, 0, 0, 1'b1);
        rst = 1'b0;
        btn_in = 4'b0001; step(); chk("bp_e1", 0, 0, 0, 0, 1'b1);
        btn_in = 4'b0000; step(); chk("bp_e2", 1, 0, 1, 0, 1'b0);
        btn_in = 4'b1000; step(); chk("bp_e3", 1, 0, 1, 0, 1'b0);
        btn_in = 4'b0000; step(); chk("bp_e4", 1, 0, 1, 0, 1'b0);
        btn_in = 4'b1000; step(); chk("bp_drop_p", 1, 0, 1, 1, 1'b0);
        step();                   chk("bp_e6", 1, 0, 1, 0, 1'b0);
        btn_in = 4'b0000; step(); chk("bp_drop_r", 1, 0, 1, 1, 1'b0);
        step();                   chk("bp_e8", 1, 0, 1, 0, 1'b0);
        evt_if.evt_ready = 1'b1;
        step(); chk("bp_p3", 1, 3, 1, 0, 1'b0);
        step(); chk("bp_r0", 1, 0, 2, 0, 1'b0);
        step(); chk("bp_r3", 1, 3, 2, 0, 1'b0);
        step(); chk("bp_empty1", 0, 3, 2, 0, 1'b1);
        step(); chk("bp_empty2", 0, 3, 2, 0, 1'b1);

        // reset with several events pending and one presented
        evt_if.evt_ready = 1'b0;
        btn_in = 4'b0111; step(); chk("mr_set", 0, 3, 2, 0, 1'b1);
        step(); chk("mr_pres", 1, 0, 1, 0, 1'b0);
        btn_in = 4'b0000; step(); chk("mr_stall", 1, 0, 1, 0, 1'b0);
        rst = 1'b1; step(); chk("mr_reset", 0, 0, 0, 0, 1'b1);
        rst = 1'b0; evt_if.evt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(); chk($sformatf("mr_quiet%0d", c), 0, 0, 0, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
